// File: rtl/noc_flit_channel_splitter.sv
// Virtual-channel demultiplexer: one shared flit bus in, one independent FIFO and
// valid/ready output per virtual channel. Handshakes are registered, with no bypass paths.

package noc_pkg;
  typedef struct packed {
    int unsigned virtual_channels;
    int unsigned flit_width;
  } noc_config;

  localparam noc_config NOC_DEFAULT_CONFIG = '{virtual_channels: 2, flit_width: 16};
endpackage

interface noc_flit_if #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 16
);
  logic [CHANNELS-1:0]   valid;
  logic [CHANNELS-1:0]   ready;
  logic [FLIT_WIDTH-1:0] flit;

  modport target    (input valid, input flit, output ready);
  modport initiator (output valid, output flit, input ready);
endinterface

interface noc_flit_channel_if #(
  parameter int FLIT_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [FLIT_WIDTH-1:0] flit;

  modport initiator (output valid, output flit, input ready);
  modport target    (input valid, input flit, output ready);
endinterface

module noc_flit_channel_splitter
  import noc_pkg::*;
#(
  parameter noc_config CONFIG     = NOC_DEFAULT_CONFIG,
  parameter int        DEPTH      = 2,
  localparam int       CHANNELS   = int'(CONFIG.virtual_channels),
  localparam int       FLIT_WIDTH = int'(CONFIG.flit_width)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  noc_flit_if.target            flit_in_if,
  noc_flit_channel_if.initiator flit_out_if [CHANNELS]
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
    logic                  full, empty, wr_en, rd_en;

    // A full FIFO refuses input even when it is being drained this same cycle.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = flit_in_if.valid[gi] && !full;
    assign rd_en = flit_out_if[gi].ready && !empty;

    assign flit_in_if.ready[gi]  = !full;
    assign flit_out_if[gi].valid = !empty;
    assign flit_out_if[gi].flit  = mem_q[rd_ptr_q];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage is never reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= flit_in_if.flit;
      end
    end
  end

endmodule
